// File: rtl/bcd_to_binary_seq.sv
// Iterative packed-BCD to binary converter, one digit per clock, most significant digit first.
// Latency: done is high in the cycle after the DIGITS-th edge following the accepting edge.
// Backpressure: start is accepted only when ready=1; start during busy is dropped, never queued.
// Optional feature macro: BCD2BIN_ERR_CHECK_EN (flags nibbles >9 on err; when undefined err is tied 0).
module bcd_to_binary_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [4*DIGITS-1:0] shreg;
  logic [BIN_W-1:0]    acc;
  logic [2:0]          cnt;

  logic [3:0]          nib;
  logic [BIN_W-1:0]    acc_next;
  logic                accept;
  logic                last;

  // Digit currently being consumed sits in the top nibble of the shift register.
  assign nib      = shreg[4*DIGITS-1 -: 4];
  // acc*10 as shift-and-add; wraps modulo 2^BIN_W.
  assign acc_next = (acc << 3) + (acc << 1) + BIN_W'(nib);

  assign busy   = (state == S_CONV);
  assign ready  = ~busy;
  assign accept = ready & start;
  assign last   = busy && (cnt == 3'(DIGITS - 1));

  // Main FSM: capture on accept, accumulate one digit per clock, publish result with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      bin_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            shreg <= bcd_in;
            acc   <= '0;
            cnt   <= '0;
            state <= S_CONV;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CONV: begin
          acc   <= acc_next;
          shreg <= shreg << 4;
          cnt   <= cnt + 3'd1;
          if (last) begin
            bin_out <= acc_next;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BCD2BIN_ERR_CHECK_EN
  logic nib_bad;
  logic sticky;
  logic err_q;

  assign nib_bad = (nib > 4'd9);
  assign err     = err_q;

  // Sticky invalid-digit flag per conversion; latched to err on the edge that raises done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        sticky <= 1'b0;
      end else if (busy) begin
        sticky <= sticky | nib_bad;
      end
      if (last) begin
        err_q <= sticky | nib_bad;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
